// File: rtl/pipeline_staller_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package pipeline_staller_pkg;

    // Control code seen by every pipeline register and the PC register.
    typedef enum logic [1:0] {
        GO     = 2'b00,
        STALL  = 2'b01,
        BUBBLE = 2'b10
    } stl_t;

    // Controller state: normal running, or waiting to drop a wrong-path fetch.
    typedef enum logic {
        S_RUN        = 1'b0,
        S_FLUSH_PEND = 1'b1
    } state_t;

    // One control code per register, ordered from PC down to MEM_WB.
    typedef struct packed {
        stl_t pc;
        stl_t if_id;
        stl_t id_ex;
        stl_t ex_mem;
        stl_t mem_wb;
    } stl_bus_t;

    // Every register receives the same code.
    function automatic stl_bus_t ctl_all(input stl_t code);
        stl_bus_t c;
        c.pc     = code;
        c.if_id  = code;
        c.id_ex  = code;
        c.ex_mem = code;
        c.mem_wb = code;
        return c;
    endfunction

    // Memory wait: freeze everything up to EX_MEM and drain a bubble into MEM_WB.
    function automatic stl_bus_t ctl_mem_wait();
        stl_bus_t c;
        c        = ctl_all(STALL);
        c.mem_wb = BUBBLE;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_staller_hazard_cmp.sv
// Combinational load-use detector: a load in the producing stage whose
// non-zero destination matches a source read by the consuming stage.
// Kept generic so it can also serve a later MEM-stage check.
module hazard_cmp (
    input  logic       ld,
    input  logic       wreg,
    input  logic [4:0] waddr,
    input  logic       re1,
    input  logic [4:0] raddr1,
    input  logic       re2,
    input  logic [4:0] raddr2,
    output logic       hit
);

    // Match either source operand against the load destination; x0 never hazards.
    always_comb begin
        if (ld && wreg && (waddr != 5'd0)) begin
            hit = (re1 && (raddr1 == waddr)) || (re2 && (raddr2 == waddr));
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_staller.sv
// Central hazard/stall controller for the 5-stage pipeline. Produces the
// Go/Stall/Bubble code for the PC and every pipeline register, tracks a
// wrong-path fetch left in flight by a flush, and counts PC stall cycles.
module pipeline_staller
    import pipeline_staller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             if_busy_i,
    input  logic             if_done_i,
    input  logic             mem_busy_i,
    input  logic             br_taken_EX_i,
    input  logic             ld_EX_i,
    input  logic             wreg_EX_i,
    input  logic [4:0]       waddr_EX_i,
    input  logic             re1_ID_i,
    input  logic [4:0]       raddr1_ID_i,
    input  logic             re2_ID_i,
    input  logic [4:0]       raddr2_ID_i,
    output logic [1:0]       stl_PC_o,
    output logic [1:0]       stl_IF_ID_o,
    output logic [1:0]       stl_ID_EX_o,
    output logic [1:0]       stl_EX_MEM_o,
    output logic [1:0]       stl_MEM_WB_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t           state;
    state_t           state_nxt;
    stl_bus_t         ctl;
    logic             lu;
    logic [CNT_W-1:0] stall_cnt;

    hazard_cmp u_hazard_cmp (
        .ld     (ld_EX_i),
        .wreg   (wreg_EX_i),
        .waddr  (waddr_EX_i),
        .re1    (re1_ID_i),
        .raddr1 (raddr1_ID_i),
        .re2    (re2_ID_i),
        .raddr2 (raddr2_ID_i),
        .hit    (lu)
    );

    // Priority resolution of the control codes and the next controller state.
    always_comb begin
        ctl       = ctl_all(GO);
        state_nxt = state;
        if (rst) begin
            // Codes read Go for the whole reset window, not just after the edge.
            ctl       = ctl_all(GO);
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_busy_i) begin
                        // EX is held, so any branch/load-use is seen again later.
                        ctl = ctl_mem_wait();
                    end else if (br_taken_EX_i) begin
                        ctl.pc     = GO;
                        ctl.if_id  = BUBBLE;
                        ctl.id_ex  = BUBBLE;
                        ctl.ex_mem = GO;
                        ctl.mem_wb = GO;
                        // A fetch still outstanding belongs to the wrong path.
                        if (if_busy_i && !if_done_i) begin
                            state_nxt = S_FLUSH_PEND;
                        end else begin
                            state_nxt = S_RUN;
                        end
                    end else if (lu) begin
                        // One bubble; forwarding covers the following cycle.
                        ctl.pc     = STALL;
                        ctl.if_id  = STALL;
                        ctl.id_ex  = BUBBLE;
                        ctl.ex_mem = GO;
                        ctl.mem_wb = GO;
                    end else if (if_busy_i) begin
                        ctl.pc    = STALL;
                        ctl.if_id = BUBBLE;
                    end else begin
                        ctl = ctl_all(GO);
                    end
                end
                S_FLUSH_PEND: begin
                    // PC waits for the wrong-path fetch; its data never enters IF_ID.
                    ctl.pc    = STALL;
                    ctl.if_id = BUBBLE;
                    if (mem_busy_i) begin
                        ctl.id_ex  = STALL;
                        ctl.ex_mem = STALL;
                        ctl.mem_wb = BUBBLE;
                        state_nxt  = S_FLUSH_PEND;
                    end else begin
                        if (lu) begin
                            ctl.id_ex = BUBBLE;
                        end else begin
                            ctl.id_ex = GO;
                        end
                        ctl.ex_mem = GO;
                        ctl.mem_wb = GO;
                        if (if_done_i) begin
                            state_nxt = S_RUN;
                        end else begin
                            state_nxt = S_FLUSH_PEND;
                        end
                    end
                end
                default: begin
                    ctl       = ctl_all(GO);
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall-cycle counter: counts edges where the PC is not advancing, saturating.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if ((ctl.pc != GO) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    assign stl_PC_o     = ctl.pc;
    assign stl_IF_ID_o  = ctl.if_id;
    assign stl_ID_EX_o  = ctl.id_ex;
    assign stl_EX_MEM_o = ctl.ex_mem;
    assign stl_MEM_WB_o = ctl.mem_wb;
    assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_pipeline_staller.sv
// Bench for pipeline_staller: directed vector table, hand sequences for
// flush/reset/saturation, and randomized stimulus against a reference model.
module tb_pipeline_staller;

    typedef struct packed {
        logic       if_busy;
        logic       if_done;
        logic       mem_busy;
        logic       br;
        logic       ld;
        logic       wreg;
        logic [4:0] waddr;
        logic       re1;
        logic [4:0] r1;
        logic       re2;
        logic [4:0] r2;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [9:0] stl;
        int         cnt;
    } vec_t;

    logic        dclk;
    logic        rst;
    logic        if_busy_i, if_done_i, mem_busy_i, br_taken_EX_i;
    logic        ld_EX_i, wreg_EX_i, re1_ID_i, re2_ID_i;
    logic [4:0]  waddr_EX_i, raddr1_ID_i, raddr2_ID_i;
    logic [1:0]  stl_PC_o, stl_IF_ID_o, stl_ID_EX_o, stl_EX_MEM_o, stl_MEM_WB_o;
    logic [1:0]  s4_pc, s4_if_id, s4_id_ex, s4_ex_mem, s4_mem_wb;
    logic [31:0] stall_cnt_o;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit     m_pend;
    longint m_cnt;
    int     m_cnt4;

    pipeline_staller #(.CNT_W(32)) dut (
        .dclk(dclk), .rst(rst),
        .if_busy_i(if_busy_i), .if_done_i(if_done_i), .mem_busy_i(mem_busy_i),
        .br_taken_EX_i(br_taken_EX_i), .ld_EX_i(ld_EX_i), .wreg_EX_i(wreg_EX_i),
        .waddr_EX_i(waddr_EX_i), .re1_ID_i(re1_ID_i), .raddr1_ID_i(raddr1_ID_i),
        .re2_ID_i(re2_ID_i), .raddr2_ID_i(raddr2_ID_i),
        .stl_PC_o(stl_PC_o), .stl_IF_ID_o(stl_IF_ID_o), .stl_ID_EX_o(stl_ID_EX_o),
        .stl_EX_MEM_o(stl_EX_MEM_o), .stl_MEM_WB_o(stl_MEM_WB_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipeline_staller #(.CNT_W(4)) dut4 (
        .dclk(dclk), .rst(rst),
        .if_busy_i(if_busy_i), .if_done_i(if_done_i), .mem_busy_i(mem_busy_i),
        .br_taken_EX_i(br_taken_EX_i), .ld_EX_i(ld_EX_i), .wreg_EX_i(wreg_EX_i),
        .waddr_EX_i(waddr_EX_i), .re1_ID_i(re1_ID_i), .raddr1_ID_i(raddr1_ID_i),
        .re2_ID_i(re2_ID_i), .raddr2_ID_i(raddr2_ID_i),
        .stl_PC_o(s4_pc), .stl_IF_ID_o(s4_if_id), .stl_ID_EX_o(s4_id_ex),
        .stl_EX_MEM_o(s4_ex_mem), .stl_MEM_WB_o(s4_mem_wb),
        .stall_cnt_o(stall_cnt4)
    );

    initial begin
        dclk = 1'b0;
        forever #5 dclk = ~dclk;
    end

    function automatic stim_t mk(input bit ifb, input bit ifd, input bit mem, input bit br,
                                 input bit ld, input bit wreg, input int waddr,
                                 input bit re1, input int r1, input bit re2, input int r2);
        stim_t s;
        s.if_busy = ifb;  s.if_done = ifd;  s.mem_busy = mem;  s.br = br;
        s.ld = ld;        s.wreg = wreg;    s.waddr = 5'(waddr);
        s.re1 = re1;      s.r1 = 5'(r1);    s.re2 = re2;       s.r2 = 5'(r2);
        return s;
    endfunction

    // Load-use hazard exactly as defined: load writing a non-zero reg that ID reads.
    function automatic bit model_lu(input stim_t s);
        return s.ld && s.wreg && (s.waddr != 5'd0) &&
               ((s.re1 && s.r1 == s.waddr) || (s.re2 && s.r2 == s.waddr));
    endfunction

    // Per-register decision written as conditions rather than a priority chain.
    function automatic logic [9:0] model_stl(input stim_t s, input bit pend);
        bit lu;
        logic [1:0] pc, ifid, idex, exmem, memwb;
        lu    = model_lu(s);
        pc    = (s.mem_busy || pend || ((lu || s.if_busy) && !s.br)) ? 2'b01 : 2'b00;
        if (pend || (!s.mem_busy && (s.br || (s.if_busy && !lu))))
            ifid = 2'b10;
        else if (s.mem_busy || lu)
            ifid = 2'b01;
        else
            ifid = 2'b00;
        if (s.mem_busy)                 idex = 2'b01;
        else if ((s.br && !pend) || lu) idex = 2'b10;
        else                            idex = 2'b00;
        exmem = s.mem_busy ? 2'b01 : 2'b00;
        memwb = s.mem_busy ? 2'b10 : 2'b00;
        return {pc, ifid, idex, exmem, memwb};
    endfunction

    task automatic drive(input stim_t s);
        if_busy_i = s.if_busy;  if_done_i = s.if_done;  mem_busy_i = s.mem_busy;
        br_taken_EX_i = s.br;   ld_EX_i = s.ld;         wreg_EX_i = s.wreg;
        waddr_EX_i = s.waddr;   re1_ID_i = s.re1;       raddr1_ID_i = s.r1;
        re2_ID_i = s.re2;       raddr2_ID_i = s.r2;
    endtask

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [9:0] dut_stl();
        return {stl_PC_o, stl_IF_ID_o, stl_ID_EX_o, stl_EX_MEM_o, stl_MEM_WB_o};
    endfunction

    function automatic logic [9:0] dut4_stl();
        return {s4_pc, s4_if_id, s4_id_ex, s4_ex_mem, s4_mem_wb};
    endfunction

    // One cycle: drive, check mid-cycle against model (and table if given), clock, update model.
    task automatic step(input stim_t s, input string name, input bit has_tbl,
                        input logic [9:0] tbl_stl, input int tbl_cnt);
        logic [9:0] exp;
        drive(s);
        #2;
        exp = model_stl(s, m_pend);
        if (has_tbl) begin
            check({name, "_tbl_stl"}, longint'(dut_stl()), longint'(tbl_stl));
            check({name, "_tbl_cnt"}, longint'(stall_cnt_o), longint'(tbl_cnt));
        end
        check({name, "_stl"}, longint'(dut_stl()), longint'(exp));
        check({name, "_stl4"}, longint'(dut4_stl()), longint'(exp));
        check({name, "_cnt"}, longint'(stall_cnt_o), m_cnt);
        check({name, "_cnt4"}, longint'(stall_cnt4), longint'(m_cnt4));
        @(posedge dclk);
        if (exp[9:8] != 2'b00) begin
            if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        end
        if (m_pend) m_pend = s.mem_busy ? 1'b1 : !s.if_done;
        else        m_pend = !s.mem_busy && s.br && s.if_busy && !s.if_done;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge dclk);
        #2;
        check("reset_stl", longint'(dut_stl()), 0);
        check("reset_cnt", longint'(stall_cnt_o), 0);
        check("reset_cnt4", longint'(stall_cnt4), 0);
        @(posedge dclk);
        #1;
        rst = 1'b0;
        m_pend = 1'b0; m_cnt = 0; m_cnt4 = 0;
    endtask

    vec_t  tbl[22];
    stim_t idle, st;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //           ifb ifd mem br ld wr wa re1 r1 re2 r2      PC IF ID EM MW   cnt
        tbl[0]  = '{mk(0, 0, 0, 0, 1, 1, 5, 1, 5, 0, 0), 10'b01_01_10_00_00, 0};
        tbl[1]  = '{idle,                                10'b00_00_00_00_00, 1};
        tbl[2]  = '{mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0), 10'b00_00_00_00_00, 1};
        tbl[3]  = '{mk(0, 0, 0, 0, 1, 1, 7, 1, 3, 1, 7), 10'b01_01_10_00_00, 1};
        tbl[4]  = '{mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 7), 10'b00_00_00_00_00, 2};
        tbl[5]  = '{mk(0, 0, 0, 0, 1, 1, 7, 0, 7, 0, 7), 10'b00_00_00_00_00, 2};
        tbl[6]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 2};
        tbl[7]  = '{mk(0, 0, 1, 1, 1, 1, 5, 1, 5, 0, 0), 10'b01_01_01_01_10, 3};
        tbl[8]  = '{mk(0, 0, 0, 1, 1, 1, 5, 1, 5, 0, 0), 10'b00_10_10_00_00, 4};
        tbl[9]  = '{mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b00_10_10_00_00, 4};
        tbl[10] = '{idle,                                10'b00_00_00_00_00, 4};
        tbl[11] = '{mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b00_10_10_00_00, 4};
        tbl[12] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 4};
        tbl[13] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 5};
        tbl[14] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 6};
        tbl[15] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 7};
        tbl[16] = '{idle,                                10'b00_00_00_00_00, 8};
        tbl[17] = '{mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b00_10_10_00_00, 8};
        tbl[18] = '{mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_01_01_10, 8};
        tbl[19] = '{mk(1, 0, 0, 0, 1, 1, 5, 1, 5, 0, 0), 10'b01_10_10_00_00, 9};
        tbl[20] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b01_10_00_00_00, 10};
        tbl[21] = '{idle,                                10'b00_00_00_00_00, 11};

        drive(idle);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].s, $sformatf("vec%0d", i), 1'b1, tbl[i].stl, tbl[i].cnt);
        end

        // Saturation of the 4-bit counter under a long fetch wait
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat", 1'b0, 10'b0, 0);
        end
        #2;
        check("sat_cnt4_final", longint'(stall_cnt4), 15);
        check("sat_cnt32_final", longint'(stall_cnt_o), 20);
        @(posedge dclk);
        #1;

        // Asynchronous reset while waiting on a wrong-path fetch
        do_reset();
        step(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "ar_br", 1'b0, 10'b0, 0);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar_pend", 1'b0, 10'b0, 0);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("ar_before_stl", longint'(dut_stl()), longint'(10'b01_10_00_00_00));
        rst = 1'b1;
        #1;
        check("ar_mid_stl", longint'(dut_stl()), 0);
        check("ar_mid_cnt", longint'(stall_cnt_o), 0);
        check("ar_mid_cnt4", longint'(stall_cnt4), 0);
        #2;
        rst = 1'b0;
        m_pend = 1'b0; m_cnt = 0; m_cnt4 = 0;
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar_done", 1'b1, 10'b00_00_00_00_00, 0);
        step(idle, "ar_idle", 1'b1, 10'b00_00_00_00_00, 0);

        // Randomized stimulus against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            st.if_busy  = 1'($urandom_range(0, 1));
            st.if_done  = ($urandom_range(0, 3) == 0);
            st.mem_busy = ($urandom_range(0, 4) == 0);
            st.br       = ($urandom_range(0, 3) == 0);
            st.ld       = 1'($urandom_range(0, 1));
            st.wreg     = 1'($urandom_range(0, 1));
            st.waddr    = 5'($urandom_range(0, 3));
            st.re1      = 1'($urandom_range(0, 1));
            st.r1       = 5'($urandom_range(0, 3));
            st.re2      = 1'($urandom_range(0, 1));
            st.r2       = 5'($urandom_range(0, 3));
            step(st, "rand", 1'b0, 10'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_staller.md
Name: pipeline_staller

Overview:
- Central hazard/stall controller for the 5-stage RISC-V pipeline.
- Produces the 2-bit control code consumed by every pipeline register and the PC register: Go (advance), Stall (hold) or Bubble (load NOP/zeros).
- Resolves, in priority order: memory-port wait, taken branch/jump flush, load-use hazard, instruction-fetch wait.
- Tracks wrong-path fetches still in flight after a flush, and keeps a stall-cycle performance counter.

Parameters:
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
dclk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
if_busy_i  in  1  instruction fetch not yet returned this cycle
if_done_i  in  1  single-cycle pulse: the in-flight fetch has returned
mem_busy_i  in  1  MEM stage is waiting on data memory
br_taken_EX_i  in  1  EX resolved a taken branch or jump
ld_EX_i  in  1  instruction in EX is a load
wreg_EX_i  in  1  instruction in EX writes a register
waddr_EX_i  in  5  destination register of the instruction in EX
re1_ID_i  in  1  ID reads rs1
raddr1_ID_i  in  5  rs1 address in ID
re2_ID_i  in  1  ID reads rs2
raddr2_ID_i  in  5  rs2 address in ID
stl_PC_o  out  2  control code for the PC register
stl_IF_ID_o  out  2  control code for the IF_ID register
stl_ID_EX_o  out  2  control code for the ID_EX register
stl_EX_MEM_o  out  2  control code for the EX_MEM register
stl_MEM_WB_o  out  2  control code for the MEM_WB register
stall_cnt_o  out  CNT_W  count of cycles in which stl_PC_o is not Go

Behaviour:
- Reset is asynchronous and active-high on rst.
- Codes: Go = 2'b00, Stall = 2'b01, Bubble = 2'b10. 2'b11 is never driven.
- Control outputs are combinational, derived from the inputs and the state register. They are sampled by the pipeline registers at the same dclk edge.

Reset (rst = 1):
- State goes to S_RUN; stall_cnt_o = 0.
- All stl_*_o = Go. The registers reset themselves independently.

Load-use hazard (lu) is defined as:
- ld_EX_i & wreg_EX_i & waddr_EX_i != 0, and
- (re1_ID_i & raddr1_ID_i == waddr_EX_i) | (re2_ID_i & raddr2_ID_i == waddr_EX_i).

Priority in S_RUN (the first matching rule applies):
1. mem_busy_i: PC, IF_ID, ID_EX and EX_MEM = Stall; MEM_WB = Bubble. A branch or load-use seen in the same cycle is re-evaluated on a later cycle, because the EX contents are held.
2. br_taken_EX_i: PC = Go (loads the target); IF_ID and ID_EX = Bubble; EX_MEM and MEM_WB = Go.
   - If if_busy_i & ~if_done_i in the same cycle, the outstanding fetch is wrong-path. Next state is S_FLUSH_PEND.
3. lu: PC and IF_ID = Stall; ID_EX = Bubble; EX_MEM and MEM_WB = Go.
   - Exactly one bubble is inserted; the next cycle is resolved by MEM-to-EX forwarding.
   - lu does not re-trigger, because EX then holds a NOP.
4. if_busy_i: PC = Stall; IF_ID = Bubble; all others = Go.
5. Otherwise: all outputs = Go.

S_FLUSH_PEND (waiting to discard the wrong-path fetch):
- PC = Stall and IF_ID = Bubble.
- ID_EX, EX_MEM and MEM_WB follow rules 1 and 3–5 (rule 2 is impossible, since EX holds a bubble).
- On if_done_i, the returned data is discarded: IF_ID stays Bubble and next state is S_RUN.
- In the following cycle the PC issues the fetch of the branch target.
- mem_busy_i during S_FLUSH_PEND still applies rule 1, and the state is kept.

Counter:
- stall_cnt_o increments at each dclk edge where stl_PC_o != Go.
- It saturates at all-ones and never wraps.

Reset during S_FLUSH_PEND:
- Returns to S_RUN immediately, because reset is asynchronous. The bench checks this between clock edges.

Decomposition:
- macro.vh gains:
  - `Go, `Stall, `Bubble (2-bit);
  - `StlBus [1:0];
  - state encodings `S_RUN = 1'b0, `S_FLUSH_PEND = 1'b1.
- Sub-module hazard_cmp: purely combinational lu detection. It is reusable later for the MEM-stage load-use check.
- The FSM, priority mux and counter live in the top module.

Test Plan:
- Load-use: ld_EX_i=1, wreg=1, waddr_EX=5, re1_ID=1, raddr1_ID=5 -> PC=01, IF_ID=01, ID_EX=10, EX_MEM=00. The following cycle (ld_EX_i=0) is all 00. stall_cnt_o = 1.
- x0 case: the same stimulus with waddr_EX=0 -> all 00, and the counter is unchanged.
- Branch with fetch in flight: br_taken=1, if_busy=1 -> PC=00, IF_ID=10, ID_EX=10. Hold if_busy for 3 cycles -> PC=01, IF_ID=10 each cycle. if_done pulse -> IF_ID=10, then back to S_RUN with all 00.
- Memory wait over hazards: mem_busy=1 together with br_taken=1 and lu -> PC, IF_ID, ID_EX, EX_MEM = 01 and MEM_WB = 10. Drop mem_busy -> branch rule applies (PC=00, IF_ID=10).
- Saturation: CNT_W=4, hold if_busy=1 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.
- Asynchronous reset: assert rst mid-cycle while in S_FLUSH_PEND -> the counter reads 0 and all outputs read 00 before the next dclk edge. After release, if_done has no effect.
